// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and default constants for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } arb_state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_DWIDTH  = 8;
    // One 10-bit frame at 1 MHz / 9600 baud is about 1042 cycles; leave headroom.
    localparam int DEF_TIMEOUT = 2048;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signals seen by the arbiter
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int DWIDTH = DEF_DWIDTH
);
    localparam int IW = $clog2(NREQ);

    // requester side
    logic [NREQ-1:0]        req;
    logic [NREQ*DWIDTH-1:0] din;
    logic [NREQ-1:0]        ack;
    logic                   busy;
    logic [IW-1:0]          grant_id;
    logic                   timeout_err;
    // transmitter side
    logic                   newd;
    logic [DWIDTH-1:0]      dintx;
    logic                   donetx;

    // the arbiter itself
    modport slave (
        input  req, din, donetx,
        output ack, busy, grant_id, newd, dintx, timeout_err
    );

    // requesters plus transmitter, as seen from the surrounding logic
    modport master (
        output req, din, donetx,
        input  ack, busy, grant_id, newd, dintx, timeout_err
    );

endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin search starting after the last winner
module uart_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    found,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int IW = $clog2(NREQ);

    int pos;

    // Walk from the farthest slot toward last+1 so the nearest set bit overwrites the rest.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int off = NREQ; off >= 1; off--) begin
            pos = (int'(last) + off) % NREQ;
            if (req[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter among NREQ requesters
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int              IW       = $clog2(NREQ);
    localparam int              CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    arb_state_t        state, state_next;
    logic [IW-1:0]     last, last_next;
    logic [IW-1:0]     grant_r, grant_next;
    logic [DWIDTH-1:0] dintx_r, dintx_next;
    logic [NREQ-1:0]   ack_r, ack_next;
    logic              newd_r, newd_next;
    logic              err_r, err_next;
    logic              busy_r, busy_next;
    // Set when ACK was entered by the watchdog: ack is then issued one cycle later.
    logic              late_ack, late_next;
    logic [CW-1:0]     cnt;
    logic              donetx_q;
    logic              done_rise;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;

    uart_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (bus.req),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Only a fresh edge completes a frame; a level left over from the last frame does not.
    assign done_rise = bus.donetx & ~donetx_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_next = state;
        last_next  = last;
        grant_next = grant_r;
        dintx_next = dintx_r;
        ack_next   = '0;
        newd_next  = 1'b0;
        err_next   = 1'b0;
        late_next  = late_ack;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = LOAD;
                    newd_next  = 1'b1;
                    grant_next = pick_idx;
                    dintx_next = bus.din[int'(pick_idx)*DWIDTH +: DWIDTH];
                end
            end
            LOAD: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    state_next = ACK;
                    ack_next   = ONE_HOT0 << grant_r;
                    late_next  = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ACK;
                    err_next   = 1'b1;
                    late_next  = 1'b1;
                end
            end
            ACK: begin
                if (late_ack) begin
                    ack_next  = ONE_HOT0 << grant_r;
                    late_next = 1'b0;
                end else begin
                    state_next = IDLE;
                    last_next  = grant_r;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // Registered outputs, grant bookkeeping and the byte latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last     <= IW'(NREQ - 1);
            grant_r  <= '0;
            dintx_r  <= '0;
            ack_r    <= '0;
            newd_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            late_ack <= 1'b0;
        end else begin
            last     <= last_next;
            grant_r  <= grant_next;
            dintx_r  <= dintx_next;
            ack_r    <= ack_next;
            newd_r   <= newd_next;
            err_r    <= err_next;
            busy_r   <= busy_next;
            late_ack <= late_next;
        end
    end

    // Watchdog counter restarted in LOAD, and the donetx history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            donetx_q <= 1'b0;
        end else begin
            donetx_q <= bus.donetx;
            if (state == LOAD) begin
                cnt <= '0;
            end else if (state == WAIT_DONE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.ack         = ack_r;
    assign bus.busy        = busy_r;
    assign bus.grant_id    = grant_r;
    assign bus.newd        = newd_r;
    assign bus.dintx       = dintx_r;
    assign bus.timeout_err = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 2048;
    localparam int BOUND   = 5000;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   chk_en      = 0;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DWIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DWIDTH  (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: time-based view of one frame. A grant at model cycle t0 completes on the first
    // donetx rise sampled at t0+2 .. t0+1+TIMEOUT; otherwise the watchdog fires at t0+1+TIMEOUT
    // and ack follows one cycle later. The arbiter is free again the cycle after ack.
    int              m_n, m_t0, m_ack_at, m_last;
    bit              m_active, m_prev, m_rise;
    int              exp_gid;
    logic [DW-1:0]   exp_dintx;
    logic [NREQ-1:0] exp_ack;
    bit              exp_newd, exp_busy, exp_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n = 0; m_t0 = 0; m_ack_at = -1; m_last = NREQ - 1;
            m_active = 0; m_prev = 0;
            exp_gid = 0; exp_dintx = '0; exp_ack = '0;
            exp_newd = 0; exp_busy = 0; exp_err = 0;
        end else begin
            m_n    = m_n + 1;
            m_rise = bus.donetx && !m_prev;
            m_prev = bus.donetx;
            exp_newd = 0;
            exp_ack  = '0;
            exp_err  = 0;
            if (m_active) begin
                if (m_ack_at < 0) begin
                    if (m_n >= m_t0 + 2 && m_rise) begin
                        m_ack_at = m_n;
                    end else if (m_n == m_t0 + 1 + TIMEOUT) begin
                        exp_err  = 1;
                        m_ack_at = m_n + 1;
                    end
                end
                if (m_n == m_ack_at) begin
                    exp_ack[exp_gid] = 1'b1;
                end else if (m_ack_at >= 0 && m_n == m_ack_at + 1) begin
                    m_active = 0;
                    m_last   = exp_gid;
                end
            end else if (bus.req != '0) begin
                for (int off = 1; off <= NREQ; off++) begin
                    if (!m_active && bus.req[(m_last + off) % NREQ]) begin
                        m_active = 1;
                        exp_gid  = (m_last + off) % NREQ;
                    end
                end
                m_t0      = m_n;
                m_ack_at  = -1;
                exp_newd  = 1;
                exp_dintx = bus.din[exp_gid*DW +: DW];
            end
            exp_busy = m_active;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack",         64'(bus.ack),         64'(exp_ack));
            chk("busy",        64'(bus.busy),        64'(exp_busy));
            chk("grant_id",    64'(bus.grant_id),    64'(exp_gid));
            chk("newd",        64'(bus.newd),        64'(exp_newd));
            chk("dintx",       64'(bus.dintx),       64'(exp_dintx));
            chk("timeout_err", 64'(bus.timeout_err), 64'(exp_err));
        end
    end

    task automatic wait_newd(input string tag, output int gid, output int t);
        int k;
        k = 0;
        while (!bus.newd && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        gid = int'(bus.grant_id);
        t   = cyc;
        if (!bus.newd) chk({tag, "_newd_bound"}, 64'(k), 64'(0));
    endtask

    task automatic wait_ack(input string tag, input logic [NREQ-1:0] want);
        int k;
        k = 0;
        while (bus.ack == '0 && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ack"}, 64'(bus.ack), 64'(want));
    endtask

    task automatic pulse_done();
        @(negedge clk);
        bus.donetx = 1'b1;
        @(negedge clk);
        bus.donetx = 1'b0;
    endtask

    initial begin
        int g, t0, k, nack;
        logic [NREQ-1:0] onehot;
        rst = 1'b0;
        bus.req = '0;
        bus.din = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.donetx = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(bus.ack), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_gid", 64'(bus.grant_id), 64'(0));
        chk("rst_dintx", 64'(bus.dintx), 64'(0));
        chk_en = 1;
        rst = 1'b1;
        @(negedge clk);

        // fairness: all four requesting, each drops after its own ack
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            wait_newd("fair", g, t0);
            chk("fair_order", 64'(g), 64'(i));
            chk("fair_dintx", 64'(bus.dintx), 64'(8'h11 * (i + 1)));
            repeat (8) @(negedge clk);
            pulse_done();
            onehot = '0;
            onehot[i] = 1'b1;
            wait_ack("fair", onehot);
            bus.req[g] = 1'b0;
        end
        @(negedge clk);
        bus.req = 4'b1001;
        wait_newd("rearm", g, t0);
        chk("rearm_gid", 64'(g), 64'(0));
        bus.req = '0;
        pulse_done();
        wait_ack("rearm", 4'b0001);

        // single request with a realistic frame length
        @(negedge clk);
        bus.din[2*DW +: DW] = 8'hA5;
        bus.req = 4'b0100;
        wait_newd("single", g, t0);
        chk("single_gid", 64'(g), 64'(2));
        chk("single_dintx", 64'(bus.dintx), 64'(8'hA5));
        bus.req = '0;
        @(negedge clk);
        chk("single_newd_1cyc", 64'(bus.newd), 64'(0));
        repeat (1038) @(negedge clk);
        pulse_done();
        wait_ack("single", 4'b0100);
        @(negedge clk);
        chk("single_ack_1cyc", 64'(bus.ack), 64'(0));
        chk("single_busy_after", 64'(bus.busy), 64'(0));

        // stale done: level from frame 1 must not complete frame 2
        bus.req = 4'b0010;
        wait_newd("stale1", g, t0);
        chk("stale1_gid", 64'(g), 64'(1));
        bus.req = '0;
        repeat (5) @(negedge clk);
        bus.donetx = 1'b1;
        wait_ack("stale1", 4'b0010);
        bus.req = 4'b0100;
        wait_newd("stale2", g, t0);
        chk("stale2_gid", 64'(g), 64'(2));
        bus.req = '0;
        nack = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.ack != '0) nack++;
        end
        chk("stale2_no_ack", 64'(nack), 64'(0));
        bus.donetx = 1'b0;
        @(negedge clk);
        bus.donetx = 1'b1;
        wait_ack("stale2", 4'b0100);
        bus.donetx = 1'b0;

        // timeout: donetx never toggles
        @(negedge clk);
        bus.req = 4'b1000;
        wait_newd("tmo", g, t0);
        chk("tmo_gid", 64'(g), 64'(3));
        bus.req = '0;
        k = 0;
        while (!bus.timeout_err && k < TIMEOUT + 20) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_latency", 64'(cyc - t0), 64'(TIMEOUT + 1));
        chk("tmo_ack_not_yet", 64'(bus.ack), 64'(0));
        @(negedge clk);
        chk("tmo_ack", 64'(bus.ack), 64'(4'b1000));
        chk("tmo_err_1cyc", 64'(bus.timeout_err), 64'(0));
        @(negedge clk);
        chk("tmo_idle", 64'(bus.busy), 64'(0));

        // edge and watchdog expiry on the same cycle: edge wins
        bus.req = 4'b0001;
        wait_newd("tie", g, t0);
        chk("tie_gid", 64'(g), 64'(0));
        bus.req = '0;
        k = 0;
        while (cyc < t0 + TIMEOUT && k < TIMEOUT + 20) begin
            @(negedge clk);
            k++;
        end
        bus.donetx = 1'b1;
        @(negedge clk);
        chk("tie_ack", 64'(bus.ack), 64'(4'b0001));
        chk("tie_no_err", 64'(bus.timeout_err), 64'(0));
        bus.donetx = 1'b0;
        repeat (2) @(negedge clk);

        // reset in the middle of a frame
        bus.req = 4'b0100;
        wait_newd("rstm", g, t0);
        chk("rstm_gid", 64'(g), 64'(2));
        bus.req = '0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstm_async_busy", 64'(bus.busy), 64'(0));
        chk("rstm_async_gid", 64'(bus.grant_id), 64'(0));
        chk("rstm_async_dintx", 64'(bus.dintx), 64'(0));
        chk("rstm_async_newd", 64'(bus.newd), 64'(0));
        chk("rstm_async_err", 64'(bus.timeout_err), 64'(0));
        chk("rstm_async_ack", 64'(bus.ack), 64'(0));
        repeat (2) begin
            @(negedge clk);
            chk("rstm_no_ack", 64'(bus.ack), 64'(0));
        end
        rst = 1'b1;
        bus.req = 4'b1010;
        wait_newd("post_rst", g, t0);
        chk("post_rst_gid", 64'(g), 64'(1));
        chk("post_rst_dintx", 64'(bus.dintx), 64'(8'h22));
        bus.req = '0;
        repeat (4) @(negedge clk);
        pulse_done();
        wait_ack("post_rst", 4'b0010);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter inside `uart_top` between several on-chip requesters. It grants one requester at a time, latches that requester's byte, and drives the transmitter's `newd`/`dintx` inputs. It then waits for the transmitter's `donetx` completion, with a watchdog, and returns a one-cycle acknowledge to the granted requester. It sits between the requester logic and `uart_top`, in the same clock domain.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `DWIDTH`, 8: byte width, equal to the transmitter's `dintx` width
- `TIMEOUT`, 2048: clk cycles allowed in WAIT_DONE before abort. Default exceeds one 10-bit frame at 1 MHz / 9600 baud (~1042 cycles).
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `req` in NREQ: request level per requester
- `din` in NREQ*DWIDTH: requester data; slice i is `din[i*DWIDTH +: DWIDTH]`
- `ack` out NREQ: one-cycle completion pulse to the granted requester
- `busy` out 1: high in every state except IDLE
- `grant_id` out $clog2(NREQ): index of current/last granted requester
- `newd` out 1: to `uart_top.newd`; one-cycle start pulse
- `dintx` out DWIDTH: to `uart_top.dintx`; held stable from LOAD until return to IDLE
- `donetx` in 1: from `uart_top.donetx`; may stay high for many cycles
- `timeout_err` out 1: one-cycle pulse when the watchdog fires

## Operation
- FSM states: IDLE → LOAD → WAIT_DONE → ACK → IDLE.
- **IDLE:** if any `req` bit is high, pick the first set bit searching upward from `last+1`, wrapping modulo NREQ.
  - Latch `din` slice and index into `dintx`/`grant_id`.
  - Go to LOAD.
  - If no `req` bit is high, stay in IDLE.
- **LOAD:** `newd`=1 for exactly this state; always go to WAIT_DONE next.
- **WAIT_DONE:**
  - Watchdog counter counts up from 0 each cycle.
  - Completion is a rising edge of `donetx` (`donetx & ~donetx_q`). Level alone never completes, so a `donetx` still high from the previous frame is ignored.
  - Rising edge → ACK.
  - Counter == TIMEOUT-1 without edge → `timeout_err` pulse, then go to ACK. The requester is released; the byte is considered lost.
  - If the edge and the timeout occur in the same cycle, the edge wins and there is no error.
- **ACK:** `ack[grant_id]`=1; `last` ← `grant_id`; go to IDLE.
- `donetx` edges in IDLE/LOAD/ACK are ignored. `donetx_q` is always registered.
- `req` bits of non-granted requesters are don't-care until the next IDLE. `din` changes after latching are ignored.
- A requester must drop `req` in the cycle after seeing `ack`, or it is granted again. The requester is still subject to round-robin order.
- Reset (`rst`=0, any state, mid-frame included):
  - FSM → IDLE; `last` ← NREQ-1, so requester 0 has first priority.
  - Counter 0, `donetx_q` 0.
  - An in-flight byte is abandoned with no `ack`.
- Reset values: `ack`=0, `busy`=0, `grant_id`=0, `newd`=0, `dintx`=0, `timeout_err`=0.

## Timing
- All outputs are registered; there is no combinational path from an input to an output.
- `req` sampled high at edge k (in IDLE) → after edge k: `newd`=1, `dintx`/`grant_id` valid, `busy`=1.
- After edge k+1: `newd`=0.
- `donetx` rising edge sampled at edge m → `ack` high after edge m for one cycle → IDLE after edge m+1.
- Earliest next grant is at edge m+2. Back-to-back throughput: one byte per frame time + 4 cycles.
- Timeout: `timeout_err` and the transition to ACK occur at edge k+1+TIMEOUT. `ack` follows one cycle later.

## Structure
- Package `uart_arb_pkg`:
  - state enum `arb_state_t` {IDLE, LOAD, WAIT_DONE, ACK}
  - default constants for NREQ, DWIDTH, TIMEOUT
- Sub-module `uart_rr_pick`: combinational round-robin search with inputs `req` and `last`, outputs `found` and `idx`. Reused by future RX-side schedulers.
- Top level holds the FSM, data latch, watchdog counter and `donetx` edge detector.

## Test plan
- **Single request:** `req`=4'b0100, `din[2]`=8'hA5; pulse `donetx` 1040 cycles later.
  - Required: `newd` exactly 1 cycle, `dintx`=8'hA5, `grant_id`=2, `ack`=4'b0100 one cycle, `busy` low after.
- **Fairness:** `req`=4'b1111 held, each requester dropping after its own `ack`.
  - Required: grant order 0,1,2,3.
  - Then re-raise `req[0]` and `req[3]` together; next grant is 0.
- **Stale done:** hold `donetx`=1 across the end of frame 1 and into the LOAD of frame 2.
  - Required: frame 2 does not complete until `donetx` falls and rises again.
- **Timeout:** TIMEOUT=16, `donetx` never toggles.
  - Required: `timeout_err` pulse exactly 17 cycles after `newd`, `ack` the next cycle, then IDLE.
- **Reset mid-frame:** assert `rst`=0 in WAIT_DONE.
  - Required: all outputs return to reset values asynchronously, no `ack`.
  - After release with `req`=4'b1010, first grant is 1.
- **Edge/timeout tie:** `donetx` rises on the final watchdog cycle.
  - Required: `ack` is issued, `timeout_err` stays 0.
